// File: rtl/fsign_unit_pkg.sv
// Shared constants for the floating-point sign unit: operation encodings and
// the bound on pipeline depth.
package fsign_unit_pkg;

  localparam int unsigned FSIGN_NEG         = 0;
  localparam int unsigned FSIGN_ABS         = 1;
  localparam int unsigned FSIGN_NABS        = 2;
  localparam int unsigned FSIGN_COPYSIGN    = 3;

  localparam int unsigned FSIGN_LATENCY_MAX = 4;

  function automatic bit fsign_width_ok(input int unsigned w);
    return (w == 16) || (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/fsign_stage.sv
// One pipeline slot: a valid bit plus a data word, both updated only on load.
module fsign_stage #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  // Data carries no reset; it is only meaningful while r_valid is set.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fsign_unit.sv
// Sign manipulation (NEG/ABS/NABS/COPYSIGN) on raw IEEE bit patterns, followed
// by an elastic valid/ready pipeline of LATENCY slots.
module fsign_unit
  import fsign_unit_pkg::*;
#(
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned OP        = 0,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  output logic                 lhs_ready,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  output logic                 rhs_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  if (!fsign_width_ok(DATA_TYPE)) begin : g_bad_width
    $error("fsign_unit: DATA_TYPE must be 16, 32 or 64");
  end
  if (OP > FSIGN_COPYSIGN) begin : g_bad_op
    $error("fsign_unit: OP must be 0..3");
  end
  if (LATENCY > FSIGN_LATENCY_MAX) begin : g_bad_latency
    $error("fsign_unit: LATENCY must be 0..4");
  end

  logic                 w_sign;
  logic [DATA_TYPE-1:0] w_result;
  logic                 w_in_valid;
  logic                 w_acc;
  logic                 w_unused_rhs;

  always_comb begin
    w_sign = ~lhs[DATA_TYPE-1];
    case (OP)
      FSIGN_ABS:      w_sign = 1'b0;
      FSIGN_NABS:     w_sign = 1'b1;
      FSIGN_COPYSIGN: w_sign = rhs[DATA_TYPE-1];
      default:        w_sign = ~lhs[DATA_TYPE-1];
    endcase
  end

  // Only the sign bit changes; NaN payloads and subnormals pass untouched.
  assign w_result     = {w_sign, lhs[DATA_TYPE-2:0]};
  assign w_unused_rhs = ^{rhs[DATA_TYPE-2:0], rhs_valid};

  if (OP == FSIGN_COPYSIGN) begin : g_join
    assign w_in_valid = lhs_valid & rhs_valid;
    assign lhs_ready  = rhs_valid & w_acc;
    assign rhs_ready  = lhs_valid & w_acc;
  end else begin : g_single
    assign w_in_valid = lhs_valid;
    assign lhs_ready  = w_acc;
    assign rhs_ready  = 1'b0;
  end

  if (LATENCY == 0) begin : g_comb
    logic w_unused_clk;
    assign w_unused_clk = clk;
    assign outs         = w_result;
    assign outs_valid   = w_in_valid;
    assign w_acc        = outs_ready & ~rst;
  end else begin : g_pipe
    logic [DATA_TYPE-1:0] w_stage_data [LATENCY];
    logic [LATENCY-1:0]   w_stage_valid;
    logic [LATENCY-1:0]   w_load;

    for (genvar k = 0; k < int'(LATENCY); k++) begin : g_stage
      logic [DATA_TYPE-1:0] w_up_data;
      logic                 w_up_valid;

      if (k == 0) begin : g_head
        assign w_up_data  = w_result;
        assign w_up_valid = w_in_valid;
      end else begin : g_body
        assign w_up_data  = w_stage_data[k-1];
        assign w_up_valid = w_stage_valid[k-1];
      end

      // Slot k can load unless it and every slot after it are full and the
      // consumer is stalling; this is the backward ready chain, flattened.
      assign w_load[k] = outs_ready | ~(&w_stage_valid[LATENCY-1:k]);

      fsign_stage #(.DW(DATA_TYPE)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[k]),
        .i_valid (w_up_valid),
        .i_data  (w_up_data),
        .o_valid (w_stage_valid[k]),
        .o_data  (w_stage_data[k])
      );
    end

    assign outs       = w_stage_data[LATENCY-1];
    assign outs_valid = w_stage_valid[LATENCY-1];
    assign w_acc      = w_load[0] & ~rst;
  end

endmodule

// File: tb/tb_fsign_unit.sv
// Scoreboard bench for fsign_unit: four configurations driven with directed
// and random traffic, compared against a plain-arithmetic sign model.
module tb_fsign_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, b_rst;
  int   checks = 0;
  int   failures = 0;
  int   c_acc = 0;

  // a: NEG, 32-bit, latency 1
  logic [31:0] a_lhs, a_rhs, a_outs;
  logic        a_lv, a_lr, a_rv, a_rr, a_ov, a_or;
  // b: ABS, 64-bit, latency 3, private reset
  logic [63:0] b_lhs, b_rhs, b_outs;
  logic        b_lv, b_lr, b_rv, b_rr, b_ov, b_or;
  // c: COPYSIGN, 32-bit, latency 2
  logic [31:0] c_lhs, c_rhs, c_outs;
  logic        c_lv, c_lr, c_rv, c_rr, c_ov, c_or;
  // z: NABS, 16-bit, latency 0
  logic [15:0] z_lhs, z_rhs, z_outs;
  logic        z_lv, z_lr, z_rv, z_rr, z_ov, z_or;

  logic [63:0] a_q[$], b_q[$], c_q[$];

  fsign_unit #(.DATA_TYPE(32), .OP(0), .LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .lhs(a_lhs), .lhs_valid(a_lv), .lhs_ready(a_lr),
    .rhs(a_rhs), .rhs_valid(a_rv), .rhs_ready(a_rr),
    .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or));
  fsign_unit #(.DATA_TYPE(64), .OP(1), .LATENCY(3)) u_b (
    .clk(clk), .rst(b_rst), .lhs(b_lhs), .lhs_valid(b_lv), .lhs_ready(b_lr),
    .rhs(b_rhs), .rhs_valid(b_rv), .rhs_ready(b_rr),
    .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or));
  fsign_unit #(.DATA_TYPE(32), .OP(3), .LATENCY(2)) u_c (
    .clk(clk), .rst(rst), .lhs(c_lhs), .lhs_valid(c_lv), .lhs_ready(c_lr),
    .rhs(c_rhs), .rhs_valid(c_rv), .rhs_ready(c_rr),
    .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or));
  fsign_unit #(.DATA_TYPE(16), .OP(2), .LATENCY(0)) u_z (
    .clk(clk), .rst(rst), .lhs(z_lhs), .lhs_valid(z_lv), .lhs_ready(z_lr),
    .rhs(z_rhs), .rhs_valid(z_rv), .rhs_ready(z_rr),
    .outs(z_outs), .outs_valid(z_ov), .outs_ready(z_or));

  // Reference: keep the magnitude bits, pick the sign by the operation's rule.
  function automatic logic [63:0] ref_sign(input int op, input int dw,
                                           input logic [63:0] l, input logic [63:0] r);
    logic [63:0] sbit;
    logic [63:0] mag;
    bit          s;
    sbit = 64'd1 << dw - 1;
    mag  = l & (sbit - 64'd1);
    case (op)
      0:       s = (l & sbit) == 64'd0;
      1:       s = 1'b0;
      2:       s = 1'b1;
      default: s = (r & sbit) != 64'd0;
    endcase
    return s ? (mag | sbit) : mag;
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h7FF0_0000_7F80_7C00;
      3:       return 64'h8000_0000_8000_8000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard push: record the expected result of every input transfer.
  always @(negedge clk) begin
    if (rst) begin
      a_q.delete();
      c_q.delete();
    end else begin
      if (a_lv && a_lr) a_q.push_back(ref_sign(0, 32, 64'(a_lhs), 64'(a_rhs)));
      if (c_lv && c_rv && c_lr) begin
        c_q.push_back(ref_sign(3, 32, 64'(c_lhs), 64'(c_rhs)));
        c_acc++;
      end
    end
    if (b_rst) b_q.delete();
    else if (b_lv && b_lr) b_q.push_back(ref_sign(1, 64, b_lhs, b_rhs));
  end

  // Monitor: pop and compare whenever a token leaves; plus handshake rules.
  always @(negedge clk) begin
    if (a_ov && a_or) begin
      check("a_pending", 64'(a_q.size() > 0), 64'd1);
      if (a_q.size() > 0) check("a_outs", 64'(a_outs), a_q.pop_front());
    end
    if (b_ov && b_or) begin
      check("b_pending", 64'(b_q.size() > 0), 64'd1);
      if (b_q.size() > 0) check("b_outs", b_outs, b_q.pop_front());
    end
    if (c_ov && c_or) begin
      check("c_pending", 64'(c_q.size() > 0), 64'd1);
      if (c_q.size() > 0) check("c_outs", 64'(c_outs), c_q.pop_front());
    end
    if (!rst) begin
      check("a_rready_zero", 64'(a_rr), 64'd0);
      if (!c_rv) check("c_lready_join", 64'(c_lr), 64'd0);
      if (!c_lv) check("c_rready_join", 64'(c_rr), 64'd0);
      check("z_lready", 64'(z_lr), 64'(z_or));
      check("z_rready_zero", 64'(z_rr), 64'd0);
      check("z_ovalid", 64'(z_ov), 64'(z_lv));
      if (z_lv) check("z_outs", 64'(z_outs), ref_sign(2, 16, 64'(z_lhs), 64'(z_rhs)));
    end
  end

  logic [31:0] bp_l0, bp_r0;

  initial begin
    int base;
    int lat;
    rst = 1'b1; b_rst = 1'b1;
    a_lhs = '0; a_rhs = '0; a_lv = 1'b1; a_rv = 1'b0; a_or = 1'b1;
    b_lhs = '0; b_rhs = '0; b_lv = 1'b1; b_rv = 1'b0; b_or = 1'b1;
    c_lhs = '0; c_rhs = '0; c_lv = 1'b1; c_rv = 1'b1; c_or = 1'b1;
    z_lhs = '0; z_rhs = '0; z_lv = 1'b0; z_rv = 1'b0; z_or = 1'b0;
    bp_l0 = '0; bp_r0 = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_a_lready", 64'(a_lr), 64'd0);
    check("rst_b_lready", 64'(b_lr), 64'd0);
    check("rst_c_lready", 64'(c_lr), 64'd0);
    check("rst_c_rready", 64'(c_rr), 64'd0);
    check("rst_a_ovalid", 64'(a_ov), 64'd0);
    check("rst_b_ovalid", 64'(b_ov), 64'd0);
    check("rst_c_ovalid", 64'(c_ov), 64'd0);

    // NEG, latency 1, first transfer right after reset release
    @(posedge clk); #1;
    rst = 1'b0; b_rst = 1'b0;
    b_lv = 1'b0; c_lv = 1'b0; c_rv = 1'b0;
    a_lhs = 32'h3F80_0000;
    @(posedge clk); #1;
    a_lhs = 32'h7FC0_0000;
    @(negedge clk);
    check("a_neg_one_valid", 64'(a_ov), 64'd1);
    check("a_neg_one", 64'(a_outs), 64'h0000_0000_BF80_0000);
    @(posedge clk); #1;
    a_lv = 1'b0;
    @(negedge clk);
    check("a_neg_nan", 64'(a_outs), 64'h0000_0000_FFC0_0000);

    // NABS of zero, combinational
    z_lhs = 16'h0000; z_lv = 1'b1; z_or = 1'b1;
    #1;
    check("z_nabs_zero", 64'(z_outs), 64'h0000_0000_0000_8000);
    z_lv = 1'b0;

    // ABS 64-bit, latency 3
    @(posedge clk); #1;
    b_lhs = 64'hC009_21FB_5444_2D18; b_lv = 1'b1;
    @(posedge clk); #1;
    b_lv = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("b_early_valid", 64'(b_ov), 64'd0);
    end
    @(negedge clk);
    check("b_abs_valid", 64'(b_ov), 64'd1);
    check("b_abs_pi", b_outs, 64'h4009_21FB_5444_2D18);

    // COPYSIGN join: lhs waits three cycles for rhs
    @(posedge clk); #1;
    c_lhs = 32'h4000_0000; c_lv = 1'b1; c_rv = 1'b0;
    base = c_acc;
    repeat (3) begin
      @(negedge clk);
      check("c_wait_lready", 64'(c_lr), 64'd0);
    end
    check("c_wait_no_xfer", 64'(c_acc - base), 64'd0);
    @(posedge clk); #1;
    c_rhs = 32'h8000_0000; c_rv = 1'b1;
    @(negedge clk);
    check("c_join_lready", 64'(c_lr), 64'd1);
    @(posedge clk); #1;
    c_lv = 1'b0; c_rv = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("c_join_valid", 64'(c_ov), 64'd1);
    check("c_join_outs", 64'(c_outs), 64'h0000_0000_C000_0000);

    // Backpressure: 4 tokens against a stalled latency-2 pipe
    @(posedge clk); #1;
    c_or = 1'b0;
    base = c_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int w;
          c_lhs = $urandom; c_rhs = $urandom; c_lv = 1'b1; c_rv = 1'b1;
          if (i == 0) begin bp_l0 = c_lhs; bp_r0 = c_rhs; end
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (!c_lr && w < 40);
          check("c_bp_accept_timeout", 64'(c_lr), 64'd1);
          @(posedge clk); #1;
        end
        c_lv = 1'b0; c_rv = 1'b0;
      end
      begin
        repeat (6) @(negedge clk);
        check("c_bp_accepted", 64'(c_acc - base), 64'd2);
        check("c_bp_lready", 64'(c_lr), 64'd0);
        check("c_bp_hold_valid", 64'(c_ov), 64'd1);
        check("c_bp_hold_outs", 64'(c_outs), ref_sign(3, 32, 64'(bp_l0), 64'(bp_r0)));
        @(posedge clk); #1;
        c_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("c_bp_stream", 64'(c_ov), 64'd1);
        end
      end
    join

    // Reset with two tokens in flight in the latency-3 pipe
    @(posedge clk); #1;
    b_or = 1'b1; b_lhs = rnd_val(); b_lv = 1'b1;
    @(posedge clk); #1;
    b_lhs = rnd_val();
    @(posedge clk); #1;
    b_lv = 1'b0; b_rst = 1'b1;
    @(negedge clk);
    check("b_rst_lready", 64'(b_lr), 64'd0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    @(negedge clk);
    check("b_rst_ovalid", 64'(b_ov), 64'd0);
    @(posedge clk); #1;
    b_lhs = 64'hBFF0_0000_0000_0001; b_lv = 1'b1;
    @(posedge clk); #1;
    b_lv = 1'b0;
    lat = 1;
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (!b_ov && w < 10) begin
        @(negedge clk);
        lat++;
        w++;
      end
    end
    check("b_post_rst_latency", 64'(lat), 64'd3);
    check("b_post_rst_outs", b_outs, 64'h3FF0_0000_0000_0001);

    // Random traffic on all four instances
    fork
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        a_lhs = 32'(rnd_val()); a_rhs = $urandom;
        a_lv = 1'($urandom_range(0, 1)); a_rv = 1'($urandom_range(0, 1));
        a_or = ($urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        b_lhs = rnd_val(); b_rhs = rnd_val();
        b_lv = 1'($urandom_range(0, 1)); b_rv = 1'($urandom_range(0, 1));
        b_or = ($urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        c_lhs = 32'(rnd_val()); c_rhs = 32'(rnd_val());
        c_lv = ($urandom_range(0, 3) != 0); c_rv = ($urandom_range(0, 3) != 0);
        c_or = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        z_lhs = 16'(rnd_val()); z_rhs = 16'(rnd_val());
        z_lv = 1'($urandom_range(0, 1)); z_rv = 1'($urandom_range(0, 1));
        z_or = 1'($urandom_range(0, 1));
      end
    join

    // Drain and confirm every accepted token came out
    a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0; c_rv = 1'b0; z_lv = 1'b0;
    a_or = 1'b1; b_or = 1'b1; c_or = 1'b1; z_or = 1'b1;
    repeat (8) @(negedge clk);
    check("a_drain", 64'(a_q.size()), 64'd0);
    check("b_drain", 64'(b_q.size()), 64'd0);
    check("c_drain", 64'(c_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
